restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The block SHALL have parameter N, default 4, which sets the operand, quotient and remainder width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: dividend and divisor are presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port dividend, input, N bits: unsigned dividend.
REQ-007 The block SHALL have port divisor, input, N bits: unsigned divisor.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is held on the outputs.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port quotient, output, N bits: unsigned quotient.
REQ-011 The block SHALL have port remainder, output, N bits: unsigned remainder.
REQ-012 The block SHALL have port div_zero, output, 1 bit: the divisor of the current result was zero.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-014 Operands SHALL be accepted and registered on a clk edge where in_valid && in_ready; state -> RUN, partial remainder R (N+1 bits) = 0, iteration counter = N-1.
REQ-015 Each RUN edge SHALL perform one restoring step:
- shift {R, Q} left by one, bringing in the next dividend MSB;
- compute T = R - {0, divisor};
- if there is no borrow, R = T and the Q LSB = 1; otherwise keep R and set the Q LSB = 0.
REQ-016 After the step with counter==0, state SHALL go to DONE; out_valid SHALL first be high exactly N cycles after the accepting edge.
REQ-017 In DONE, quotient, remainder and div_zero SHALL stay stable until the edge where out_ready==1; state then -> IDLE.
REQ-018 out_ready held low SHALL stall the block in DONE indefinitely; in_valid SHALL be ignored whenever state != IDLE.
REQ-019 A new acceptance SHALL NOT occur on the same edge as a DONE->IDLE transition (minimum one IDLE cycle between results).
REQ-020 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every nonzero divisor.
REQ-021 With divisor==0, the result SHALL be quotient = all ones and remainder = dividend.

Reset
REQ-022 When rst==1 at a clk edge, the block SHALL go to IDLE with quotient=0, remainder=0, div_zero=0, out_valid=0 and in_ready=1 after the edge.
REQ-023 A reset asserted in RUN or DONE SHALL discard the operation; no out_valid pulse SHALL follow.
REQ-024 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-025 The macro DIV_ZERO_DETECT_EN SHALL control zero-divisor handling.
- When defined, an accepted zero divisor SHALL skip RUN and go directly to DONE: out_valid one cycle after acceptance, div_zero=1, and the results per REQ-021.
- When undefined, a zero divisor SHALL run all N iterations, giving the REQ-021 values naturally, and div_zero SHALL be tied to 0.

Structure
REQ-026 The FSM state encoding (IDLE/RUN/DONE) SHALL be defined in shared package restoring_divider_pkg.
REQ-027 The N+1-bit subtract-with-borrow SHALL be a sub-module borrow_lookahead.
- It SHALL have inputs a and b, outputs diff and borrow_out.
- It SHALL use generate/propagate lookahead terms, g=~a&b and p=~(a^b).

Verification
REQ-028 The bench SHALL cover, with N=4:
- dividend=13, divisor=3 -> after 4 cycles out_valid=1, quotient=4, remainder=1, div_zero=0.
- dividend=15, divisor=1 -> quotient=15, remainder=0; dividend=2, divisor=9 -> quotient=0, remainder=2.
- dividend=7, divisor=0 -> quotient=15, remainder=7; with DIV_ZERO_DETECT_EN, out_valid after 1 cycle and div_zero=1; without it, out_valid after 4 cycles and div_zero=0.
- Result 13/3 with out_ready low for 5 cycles, and in_valid pulsed during the wait -> outputs stable, in_ready=0, no second acceptance; out_ready=1 -> IDLE next cycle.
- rst asserted 2 cycles into RUN -> next cycle state IDLE, all outputs 0, in_ready=1, no out_valid.
- Exhaustive sweep of all 256 operand pairs against REQ-020/REQ-021 with a random out_ready pattern.

Source files
------------

// File: rtl/restoring_divider_pkg.sv
// Shared types for the restoring divider: FSM state encoding and counter sizing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package restoring_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a down-counter that must hold n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/borrow_lookahead.sv
// W-bit subtractor a - b built from generate/propagate borrow terms; borrow_out=1 means a < b.
// Latency: purely combinational.
// Backpressure: none.
module borrow_lookahead #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow_out
);

    logic [W-1:0] g;
    logic [W-1:0] p;

    // A bit generates a borrow when it is 0 against 1, and passes an incoming borrow when both bits match.
    assign g = ~a & b;
    assign p = ~(a ^ b);

    // Fold the borrow chain LSB first; each difference bit is the half-difference xor the incoming borrow.
    always_comb begin
        logic bin;
        bin  = 1'b0;
        diff = '0;
        for (int i = 0; i < W; i++) begin
            diff[i] = ~p[i] ^ bin;
            bin     = g[i] | (p[i] & bin);
        end
        borrow_out = bin;
    end

endmodule

// File: rtl/restoring_divider.sv
// Unsigned N-bit restoring divider, one quotient bit per clock; DIV_ZERO_DETECT_EN short-circuits a zero divisor.
// Latency: result valid N cycles after acceptance (zero divisor with DIV_ZERO_DETECT_EN: straight to DONE).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, then one IDLE cycle before next accept.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero
);

    localparam int CW = cnt_width(N);

    state_e          state_q, state_d;
    logic [N:0]      r_q, r_d;      // partial remainder
    logic [N-1:0]    q_q, q_d;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [N-1:0]    dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [N:0]      r_sh;
    logic [N-1:0]    q_sh;
    logic [N:0]      t_diff;
    logic            t_borrow;

    // After a step R is always below the divisor, so its top bit is zero and shifting it out loses nothing.
    assign r_sh = (N+1)'({r_q, q_q[N-1]});
    assign q_sh = q_q << 1;

    borrow_lookahead #(
        .W (N+1)
    ) u_sub (
        .a          (r_sh),
        .b          ({1'b0, dvs_q}),
        .diff       (t_diff),
        .borrow_out (t_borrow)
    );

`ifdef DIV_ZERO_DETECT_EN
    logic dz_q, dz_d;
`endif

    // Next-state and datapath update: accept in IDLE, one restoring step per RUN cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
`ifdef DIV_ZERO_DETECT_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    r_d     = '0;
                    q_d     = dividend;
                    dvs_d   = divisor;
                    cnt_d   = CW'(N-1);
                    state_d = RUN;
`ifdef DIV_ZERO_DETECT_EN
                    dz_d    = 1'b0;
                    if (divisor == '0) begin
                        q_d     = '1;
                        r_d     = {1'b0, dividend};
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                // No borrow means the shifted remainder covers the divisor: keep the difference, quotient bit 1.
                r_d     = t_borrow ? r_sh : t_diff;
                q_d     = q_sh;
                q_d[0]  = ~t_borrow;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = q_q;
    assign remainder = r_q[N-1:0];
`ifdef DIV_ZERO_DETECT_EN
    assign div_zero  = dz_q;
`else
    assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider (N=4): directed cases, stall, mid-run reset, full operand sweep.
// Latency: n/a.
// Backpressure: exercises out_ready stalls with a random hold pattern.
module tb_restoring_divider;

    localparam int N = 4;
`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_zero;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    restoring_divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operand pair through the input handshake and record the reference result.
    task automatic send(input logic [N-1:0] dvd, input logic [N-1:0] dvs);
        exp_t e;
        int   w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            check("send_ready_timeout", 0, 1);
            return;
        end
        if (dvs == '0) begin
            e.q = {N{1'b1}};
            e.r = dvd;
        end else begin
            e.q = dvd / dvs;
            e.r = dvd % dvs;
        end
        e.dz  = DZ_EN && (dvs == '0);
        e.lat = e.dz ? 0 : N;
        sb.push_back(e);
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Wait for out_valid (counting edges after the accepting one) and compare against the oldest entry.
    task automatic get_result(input string tag);
        exp_t e;
        int   lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            check({tag, "_valid_timeout"}, 0, 1);
            return;
        end
        check({tag, "_lat"}, lat, e.lat);
        check({tag, "_q"}, quotient, e.q);
        check({tag, "_r"}, remainder, e.r);
        check({tag, "_dz"}, div_zero, e.dz);
    endtask

    // Hold the result for 'stall' cycles (optionally poking in_valid), then take it with out_ready.
    task automatic release_result(input string tag, input int stall, input bit poke);
        logic [N-1:0] q0, r0;
        q0 = quotient;
        r0 = remainder;
        for (int k = 0; k < stall; k++) begin
            if (poke) begin
                dividend = 4'd1;
                divisor  = 4'd1;
                in_valid = 1'b1;
            end
            tick();
            check({tag, "_hold_vld"}, out_valid, 1);
            check({tag, "_hold_q"}, quotient, q0);
            check({tag, "_hold_r"}, remainder, r0);
            if (poke) check({tag, "_hold_rdy"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_rel_vld"}, out_valid, 0);
        check({tag, "_rel_idle"}, in_ready, 1);
    endtask

    initial begin
        int seen_vld;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dz", div_zero, 0);

        send(4'd13, 4'd3);  get_result("d13_3");  release_result("d13_3", 0, 1'b0);
        send(4'd15, 4'd1);  get_result("d15_1");  release_result("d15_1", 0, 1'b0);
        send(4'd2,  4'd9);  get_result("d2_9");   release_result("d2_9", 0, 1'b0);
        send(4'd7,  4'd0);  get_result("d7_0");   release_result("d7_0", 0, 1'b0);

        // Stall in DONE with in_valid pulsed; nothing new may be accepted.
        send(4'd13, 4'd3);  get_result("stall");  release_result("stall", 5, 1'b1);
        check("stall_sb_empty", sb.size(), 0);

        // Reset two cycles into RUN discards the operation.
        send(4'd13, 4'd3);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        check("mrst_in_ready", in_ready, 1);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_q", quotient, 0);
        check("mrst_r", remainder, 0);
        check("mrst_dz", div_zero, 0);
        seen_vld = 0;
        for (int k = 0; k < N + 3; k++) begin
            tick();
            if (out_valid) seen_vld++;
        end
        check("mrst_no_valid", seen_vld, 0);

        // Every operand pair, with a random hold before the result is taken.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                send(N'(a), N'(b));
                get_result("sweep");
                release_result("sweep", int'($urandom_range(0, 3)), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
